// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: sequences an external 2-digit BCD counter up to a latched
// target. Three button inputs are synchronized and edge-detected. A
// prescaler paces the count-up pulses, and the FSM handles run, pause,
// done and clear.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a start event; counter untouched
// S_RUN   | prescaler running, one cnt_x every DIV cycles until target
// S_PAUSE | prescaler frozen at its held value, no cnt_x
// S_DONE  | counter equals target; holds until clr

module bcd_timer_ctrl #(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    input  logic [7:0] target,
    input  logic [7:0] bcd_in,
    output logic       cnt_x,
    output logic       cnt_clr,
    output logic       running,
    output logic       done,
    output logic       err
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [7:0]    tgt, tgt_nxt;
    logic          cnt_clr_nxt;
    logic          err_nxt;

    // Button bit order: [0] start, [1] stop, [2] clr
    logic [2:0] btn_raw;
    logic [2:0] btn_s1, btn_s2, btn_s3;
    logic [2:0] btn_arm;
    logic [1:0] warm;
    logic [2:0] btn_ev;
    logic       start_ev, stop_ev, clr_ev;
    logic       tgt_valid;
    logic       at_tgt;

    assign btn_raw = {clr, stop, start};

    // Synchronize the buttons and track when each one has been seen low.
    // A button may only fire after a synchronized low sample. warm delays
    // arming until s2 carries real post-reset data. Because of this, a
    // button held through reset stays silent until it is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            btn_s3  <= '0;
            btn_arm <= '0;
            warm    <= '0;
        end else begin
            btn_s1  <= btn_raw;
            btn_s2  <= btn_s1;
            btn_s3  <= btn_s2;
            warm    <= {warm[0], 1'b1};
            btn_arm <= btn_arm | ({3{warm[1]}} & ~btn_s2);
        end
    end

    // Rising-edge events, resolved by priority clr > stop > start
    always_comb begin
        btn_ev   = btn_s2 & ~btn_s3 & btn_arm;
        clr_ev   = btn_ev[2];
        stop_ev  = btn_ev[1] & ~btn_ev[2];
        start_ev = btn_ev[0] & ~btn_ev[1] & ~btn_ev[2];
    end

    assign tgt_valid = (target[7:4] <= 4'd9) && (target[3:0] <= 4'd9);
    // While cnt_clr is high, bcd_in still shows the value from before the
    // clear, so the target comparison is suppressed for that cycle.
    assign at_tgt    = (bcd_in == tgt) && !cnt_clr;

    // State, prescaler, latched target and registered flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            presc   <= '0;
            tgt     <= 8'h00;
            cnt_clr <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            tgt     <= tgt_nxt;
            cnt_clr <= cnt_clr_nxt;
            err     <= err_nxt;
        end
    end

    // Next-state and register updates
    always_comb begin
        state_nxt   = state;
        presc_nxt   = presc;
        tgt_nxt     = tgt;
        cnt_clr_nxt = 1'b0;
        err_nxt     = err;
        if (clr_ev) begin
            state_nxt   = S_IDLE;
            presc_nxt   = '0;
            err_nxt     = 1'b0;
            cnt_clr_nxt = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ev) begin
                        if (tgt_valid) begin
                            tgt_nxt     = target;
                            presc_nxt   = '0;
                            cnt_clr_nxt = 1'b1;
                            state_nxt   = S_RUN;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (stop_ev) begin
                        state_nxt = S_PAUSE;
                    end else if (at_tgt) begin
                        state_nxt = S_DONE;
                    end else if (presc == PRESC_MAX) begin
                        presc_nxt = '0;
                    end else begin
                        presc_nxt = presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (start_ev) begin
                        state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Count pulse and status decode from registered state
    always_comb begin
        cnt_x   = (state == S_RUN) && (presc == PRESC_MAX) && !cnt_clr && (bcd_in != tgt);
        running = (state == S_RUN);
        done    = (state == S_DONE);
    end

endmodule
